rr_arbiter_bin: RTL and testbench
=================================

// Module: rr_arbiter_bin
// PURPOSE
//  Round-robin arbiter over NUM_REQ request lines. Produces a registered binary grant index with a
//  valid/ready handshake, feeding the downstream binary-to-one-hot decode stage (IDX_W -> NUM_REQ).
//  Fair rotation: the last-accepted winner has lowest priority in the next arbitration.
// PARAMETERS
//  NUM_REQ  16                 number of requesters, >=2, need not be a power of two
//  IDX_W    $clog2(NUM_REQ)    width of grant index; drives bin_width of the decode stage
// PORTS
//  clk          in   1        clock; all state on rising edge
//  rst_n        in   1        asynchronous active-low reset
//  req_i        in   NUM_REQ  request vector; bit k = requester k wants a grant
//  gnt_valid_o  out  1        gnt_idx_o holds a valid winner
//  gnt_ready_i  in   1        downstream accepts grant this cycle
//  gnt_idx_o    out  IDX_W    binary index of current winner
//  gnt_ack_o    out  NUM_REQ  one-hot accept strobe; bit gnt_idx_o high only in handshake cycle
// BEHAVIOUR
//  Reset: one clock, async active-low. On rst_n=0, immediately: state=IDLE, gnt_valid_o=0,
//   gnt_idx_o=0, rotation pointer ptr=0. gnt_ack_o=0 follows combinationally.
//  State machine (2 states):
//   IDLE : if |req_i -> winner = first set bit of req_i scanning ptr, ptr+1, ..., NUM_REQ-1, 0, ...,
//          ptr-1; next edge: gnt_idx_o<=winner, gnt_valid_o<=1, ->GRANT. If req_i==0 stay IDLE.
//   GRANT: gnt_idx_o, gnt_valid_o held stable until gnt_valid_o&gnt_ready_i (handshake).
//          On handshake edge: ptr<=(gnt_idx_o==NUM_REQ-1)?0:gnt_idx_o+1, gnt_valid_o<=0, ->IDLE.
//  Latency: req_i sampled in IDLE -> gnt_valid_o high next cycle. Max throughput one grant / 2 cycles.
//  gnt_ack_o = gnt_valid_o & gnt_ready_i ? (1<<gnt_idx_o) : 0 (combinational, width NUM_REQ).
//   Requester k must drop req_i[k] on the edge ending its ack cycle; IDLE then sees updated req_i.
//  No retraction: if req_i[gnt_idx_o] falls while in GRANT, grant still held until handshake.
//  New requests arriving in GRANT do not alter gnt_idx_o; they compete at next IDLE.
//  ptr changes only on handshake; arbitration in IDLE never updates ptr.
//  Wrap: ptr and scan wrap at NUM_REQ-1 -> 0; indices >= NUM_REQ never produced (non-pow2 safe).
//  gnt_ready_i while gnt_valid_o=0: ignored, no state change, gnt_ack_o=0.
//  Reset mid-GRANT: grant discarded, no ack, ptr back to 0; requester 0 highest priority after reset.
//  Index arithmetic done at IDX_W bits; priority scan via doubled request vector or masked
//   two-pass priority encode, no combinational loops.
// TESTING
//  1 Reset: rst_n=0 with req_i=16'hFFFF -> gnt_valid_o=0, gnt_idx_o=0, gnt_ack_o=0 throughout.
//  2 Single: req_i=16'h0020, ready=1 -> valid high 1 cycle after sample, idx=5, ack=16'h0020
//    same cycle; req dropped -> back to IDLE, valid=0.
//  3 Rotation: req_i=16'hFFFF held, ready=1 -> idx sequence 0,1,...,15,0 one per 2 cycles, wrap 15->0.
//  4 Backpressure: req_i bits 3,9, ready=0 for 5 cycles -> idx=3, valid=1 stable; raise req_i[1]
//    meanwhile -> no change; ready=1 -> ack 16'h0008; next grant idx=9 (ptr=4 skips 1).
//  5 Non-pow2 NUM_REQ=5 (IDX_W=3): grant 4 accepted, req_i=5'b10001 -> next idx=0; never idx>4.
//  6 Reset mid-GRANT: idx=7 pending, pulse rst_n low -> valid drops same cycle, no ack;
//    after release req_i bits 7,2 -> idx=2 (ptr=0).

Source files
------------

// File: rtl/rr_arbiter_bin.sv
// rr_arbiter_bin
//   Round-robin arbiter over NUM_REQ request lines. It produces a registered
//   binary grant index with a valid/ready handshake. The winner that was last
//   accepted has the lowest priority in the next arbitration.
//
// Ports
//   clk          in   1        clock, all state updates on the rising edge
//   rst_n        in   1        asynchronous active-low reset
//   req_i        in   NUM_REQ  request vector, bit k = requester k wants a grant
//   gnt_valid_o  out  1        gnt_idx_o holds a valid winner
//   gnt_ready_i  in   1        downstream accepts the grant this cycle
//   gnt_idx_o    out  IDX_W    binary index of the current winner
//   gnt_ack_o    out  NUM_REQ  one-hot accept strobe, high only in the handshake cycle
module rr_arbiter_bin #(
    parameter int unsigned NUM_REQ = 16,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    output logic               gnt_valid_o,
    input  logic               gnt_ready_i,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic [NUM_REQ-1:0] gnt_ack_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] win_hi;
    logic [IDX_W-1:0] win_lo;
    logic             hit_hi;
    logic             hit_lo;
    logic             handshake;

    // Two-pass priority encode: the first pass only considers requesters at
    // or above ptr; if none of them is requesting, the second pass (lowest
    // set bit overall) supplies the wrapped-around winner.
    always_comb begin
        win_hi = '0;
        win_lo = '0;
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_i[i] && !hit_lo) begin
                win_lo = IDX_W'(i);
                hit_lo = 1'b1;
            end
            if (req_i[i] && (i >= 32'(ptr)) && !hit_hi) begin
                win_hi = IDX_W'(i);
                hit_hi = 1'b1;
            end
        end
        winner = hit_hi ? win_hi : win_lo;
    end

    assign handshake = gnt_valid_o & gnt_ready_i;

    // Compared element by element so a non-power-of-two NUM_REQ never
    // indexes past the top of the vector.
    always_comb begin
        gnt_ack_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            gnt_ack_o[i] = handshake && (32'(gnt_idx_o) == i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt_valid_o <= 1'b0;
            gnt_idx_o   <= '0;
            ptr         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        gnt_idx_o   <= winner;
                        gnt_valid_o <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    // Grant is held regardless of req_i until accepted.
                    if (gnt_ready_i) begin
                        ptr         <= (gnt_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_o + 1'b1;
                        gnt_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    gnt_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_bin.sv
module tb_rr_arbiter_bin;

    logic        clk;
    logic        rst_n;

    logic [15:0] req;
    logic        ready;
    logic        valid;
    logic [3:0]  idx;
    logic [15:0] ack;

    logic [4:0]  req5;
    logic        ready5;
    logic        valid5;
    logic [2:0]  idx5;
    logic [4:0]  ack5;

    int checks;
    int errors;

    logic [3:0] q[$];
    logic [2:0] q5[$];

    rr_arbiter_bin #(.NUM_REQ(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .gnt_valid_o (valid),
        .gnt_ready_i (ready),
        .gnt_idx_o   (idx),
        .gnt_ack_o   (ack)
    );

    rr_arbiter_bin #(.NUM_REQ(5)) dut5 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req5),
        .gnt_valid_o (valid5),
        .gnt_ready_i (ready5),
        .gnt_idx_o   (idx5),
        .gnt_ack_o   (ack5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        req    = '0;
        ready  = 1'b0;
        req5   = '0;
        ready5 = 1'b0;
        q.delete();
        q5.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        req    = 16'hFFFF;
        ready  = 1'b1;
        req5   = 5'b11111;
        ready5 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
            checks++;
            if (idx !== 4'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", idx); end
            checks++;
            if (ack !== 16'h0000) begin errors++; $display("FAIL reset_ack got %h exp 0000", ack); end
            checks++;
            if (valid5 !== 1'b0 || ack5 !== 5'b0) begin
                errors++; $display("FAIL reset_dut5 got valid %b ack %b exp 0 0", valid5, ack5);
            end
        end
        rst_n  = 1'b1;
        req    = '0;
        req5   = '0;
        ready5 = 1'b0;
        // ready high while idle must be ignored
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || ack !== 16'h0000) begin
            errors++; $display("FAIL idle_ready got valid %b ack %h exp 0 0000", valid, ack);
        end
        ready = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0] e;
        do_reset();
        req   = 16'h0020;
        ready = 1'b1;
        q.push_back(4'd5);
        @(negedge clk);
        checks++;
        if (valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", valid); end
        checks++;
        if (q.size() == 0) begin
            errors++; $display("FAIL single_queue got empty exp entry");
        end else begin
            e = q.pop_front();
            if (idx !== e) begin errors++; $display("FAIL single_idx got %0d exp %0d", idx, e); end
        end
        checks++;
        if (ack !== 16'h0020) begin errors++; $display("FAIL single_ack got %h exp 0020", ack); end
        req = '0;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || ack !== 16'h0000) begin
            errors++; $display("FAIL single_idle got valid %b ack %h exp 0 0000", valid, ack);
        end
        ready = 1'b0;
    endtask

    task automatic test_rotation();
        logic [3:0]  e;
        logic [15:0] one;
        do_reset();
        req   = 16'hFFFF;
        ready = 1'b1;
        for (int k = 0; k < 17; k++) q.push_back(4'(k % 16));
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b1) begin errors++; $display("FAIL rot_valid[%0d] got %b exp 1", k, valid); end
            checks++;
            if (q.size() == 0) begin
                errors++; $display("FAIL rot_queue[%0d] got empty exp entry", k);
            end else begin
                e = q.pop_front();
                if (idx !== e) begin errors++; $display("FAIL rot_idx[%0d] got %0d exp %0d", k, idx, e); end
                one = 16'h0001;
                checks++;
                if (ack !== (one << e)) begin
                    errors++; $display("FAIL rot_ack[%0d] got %h exp %h", k, ack, one << e);
                end
            end
            @(negedge clk);
            checks++;
            if (valid !== 1'b0) begin errors++; $display("FAIL rot_gap[%0d] got %b exp 0", k, valid); end
        end
        req   = '0;
        ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [3:0] e;
        do_reset();
        req   = 16'h0208;
        ready = 1'b0;
        q.push_back(4'd3);
        q.push_back(4'd9);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b1 || idx !== q[0]) begin
                errors++; $display("FAIL bp_hold[%0d] got valid %b idx %0d exp 1 %0d", c, valid, idx, q[0]);
            end
            checks++;
            if (ack !== 16'h0000) begin errors++; $display("FAIL bp_noack[%0d] got %h exp 0000", c, ack); end
            if (c == 1) req = 16'h020A;
        end
        ready = 1'b1;
        #1;
        checks++;
        if (ack !== 16'h0008) begin errors++; $display("FAIL bp_ack got %h exp 0008", ack); end
        checks++;
        e = q.pop_front();
        if (idx !== e) begin errors++; $display("FAIL bp_idx got %0d exp %0d", idx, e); end
        req = 16'h0202;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL bp_idle got %b exp 0", valid); end
        @(negedge clk);
        checks++;
        if (q.size() == 0) begin
            errors++; $display("FAIL bp_queue got empty exp entry");
        end else begin
            e = q.pop_front();
            if (valid !== 1'b1 || idx !== e) begin
                errors++; $display("FAIL bp_next got valid %b idx %0d exp 1 %0d", valid, idx, e);
            end
        end
        checks++;
        if (ack !== 16'h0200) begin errors++; $display("FAIL bp_next_ack got %h exp 0200", ack); end
        req = '0;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_nonpow2();
        logic [2:0] e;
        logic [4:0] one;
        do_reset();
        req5   = 5'b10000;
        ready5 = 1'b1;
        q5.push_back(3'd4);
        q5.push_back(3'd0);
        @(negedge clk);
        checks++;
        e = q5.pop_front();
        if (valid5 !== 1'b1 || idx5 !== e) begin
            errors++; $display("FAIL np2_first got valid %b idx %0d exp 1 %0d", valid5, idx5, e);
        end
        checks++;
        if (ack5 !== 5'b10000) begin errors++; $display("FAIL np2_first_ack got %b exp 10000", ack5); end
        req5 = 5'b10001;
        @(negedge clk);
        @(negedge clk);
        checks++;
        e = q5.pop_front();
        if (valid5 !== 1'b1 || idx5 !== e) begin
            errors++; $display("FAIL np2_wrap got valid %b idx %0d exp 1 %0d", valid5, idx5, e);
        end
        checks++;
        if (ack5 !== 5'b00001) begin errors++; $display("FAIL np2_wrap_ack got %b exp 00001", ack5); end
        req5 = 5'b11111;
        for (int k = 0; k < 6; k++) q5.push_back(3'((k + 1) % 5));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (valid5 !== 1'b0) begin errors++; $display("FAIL np2_gap[%0d] got %b exp 0", k, valid5); end
            @(negedge clk);
            checks++;
            if (idx5 > 3'd4) begin errors++; $display("FAIL np2_range[%0d] got %0d exp <=4", k, idx5); end
            checks++;
            if (q5.size() == 0) begin
                errors++; $display("FAIL np2_queue[%0d] got empty exp entry", k);
            end else begin
                e = q5.pop_front();
                one = 5'b00001;
                if (valid5 !== 1'b1 || idx5 !== e || ack5 !== (one << e)) begin
                    errors++;
                    $display("FAIL np2_rot[%0d] got valid %b idx %0d ack %b exp 1 %0d %b",
                             k, valid5, idx5, ack5, e, one << e);
                end
            end
        end
        req5   = '0;
        @(negedge clk);
        ready5 = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        logic [3:0] e;
        do_reset();
        req   = 16'h0080;
        ready = 1'b0;
        q.push_back(4'd7);
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || idx !== q[0]) begin
            errors++; $display("FAIL mid_pending got valid %b idx %0d exp 1 %0d", valid, idx, q[0]);
        end
        rst_n = 1'b0;
        ready = 1'b1;
        q.delete();
        #1;
        checks++;
        if (valid !== 1'b0 || idx !== 4'd0) begin
            errors++; $display("FAIL mid_drop got valid %b idx %0d exp 0 0", valid, idx);
        end
        checks++;
        if (ack !== 16'h0000) begin errors++; $display("FAIL mid_noack got %h exp 0000", ack); end
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b0;
        req   = 16'h0084;
        q.push_back(4'd2);
        @(negedge clk);
        checks++;
        if (q.size() == 0) begin
            errors++; $display("FAIL mid_queue got empty exp entry");
        end else begin
            e = q.pop_front();
            if (valid !== 1'b1 || idx !== e) begin
                errors++; $display("FAIL mid_after got valid %b idx %0d exp 1 %0d", valid, idx, e);
            end
        end
        ready = 1'b1;
        #1;
        checks++;
        if (ack !== 16'h0004) begin errors++; $display("FAIL mid_ack got %h exp 0004", ack); end
        req = '0;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL mid_idle got %b exp 0", valid); end
        ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_nonpow2();
        test_reset_mid_grant();
        if (q.size() != 0 || q5.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect got %0d/%0d entries exp 0/0", q.size(), q5.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
